// File: rtl/encoder_4x2_queued_pkg.sv
// Shared widths and helpers for the queued 4-to-2 encoder.
// Latency: none (constants and pure functions only).
// Backpressure: not applicable.
package encoder_4x2_queued_pkg;

  localparam int N_REQ  = 4;
  localparam int CODE_W = 2;

  // One-hot mask for a code, used to retire the granted line from the pending set.
  function automatic logic [N_REQ-1:0] code_mask(input logic [CODE_W-1:0] code);
    return N_REQ'(1) << code;
  endfunction

endpackage

// File: rtl/encoder_4x2_queued_prio_enc.sv
// Lowest-set-index priority encoder: line 0 has the highest priority.
// Latency: purely combinational.
// Backpressure: none; any flags whether index is meaningful.
module prio_enc_4x2
  import encoder_4x2_queued_pkg::*;
(
  input  logic [N_REQ-1:0]  c,
  output logic [CODE_W-1:0] index,
  output logic              any
);

  // Scan from the top so that lower set bits overwrite higher ones.
  always_comb begin
    index = '0;
    any   = |c;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (c[i]) index = CODE_W'(i);
    end
  end

endmodule

// File: rtl/encoder_4x2_queued.sv
// Queued 4-to-2 encoder: captures request lines, issues one code at a time.
// Latency: one cycle from capture to y/v when the slot is free and nothing higher pends.
// Backpressure: v && !rdy holds y/v; new requests accumulate in p, duplicates pulse drop.
module encoder_4x2_queued
  import encoder_4x2_queued_pkg::*;
#(
  parameter int EDGE = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [0:N_REQ-1]  w,
  input  logic              en,
  input  logic              rdy,
  output logic [CODE_W-1:0] y,
  output logic              v,
  output logic              drop,
  output logic              busy
);

  logic [N_REQ-1:0]  w_vec;
  logic [N_REQ-1:0]  w_prev;
  logic [N_REQ-1:0]  p;
  logic [N_REQ-1:0]  s;
  logic [N_REQ-1:0]  c;
  logic [CODE_W-1:0] idx;
  logic              any;
  logic              slot_free;

  // Re-index the [0:3] port so bit i of every internal vector is request line i.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      w_vec[i] = w[i];
    end
  end

  // Captured requests this cycle, then merged with what is already pending.
  always_comb begin
    if (!en) begin
      s = '0;
    end else if (EDGE != 0) begin
      s = w_vec & ~w_prev;
    end else begin
      s = w_vec;
    end
    c         = p | s;
    slot_free = !v || rdy;
  end

  prio_enc_4x2 u_prio (
    .c     (c),
    .index (idx),
    .any   (any)
  );

  // Output slot, pending set and edge-detect history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y      <= '0;
      v      <= 1'b0;
      drop   <= 1'b0;
      p      <= '0;
      w_prev <= '0;
    end else begin
      w_prev <= w_vec;
      // A line re-requested while already pending is merged; flag it.
      drop   <= |(s & p);
      if (slot_free) begin
        if (any) begin
          y <= idx;
          v <= 1'b1;
          p <= c & ~code_mask(idx);
        end else begin
          v <= 1'b0;
          p <= '0;
        end
      end else begin
        p <= c;
      end
    end
  end

  assign busy = v | (|p);

endmodule

// File: tb/tb_encoder_4x2_queued.sv
module tb_encoder_4x2_queued;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] mask  = 4'b0000;   // bit i drives request line i (level instance)
  logic [3:0] mask_e = 4'b0000;  // bit i drives request line i (edge instance)
  logic       en    = 1'b0;
  logic       rdy   = 1'b1;
  logic       en_e  = 1'b0;
  logic [0:3] w, w_e;
  logic [1:0] y, y_e;
  logic       v, drop, busy, v_e, drop_e, busy_e;

  assign w   = {mask[0], mask[1], mask[2], mask[3]};
  assign w_e = {mask_e[0], mask_e[1], mask_e[2], mask_e[3]};

  always #5 clk = ~clk;

  encoder_4x2_queued #(.EDGE(0)) u_lvl (
    .clk(clk), .rst_n(rst_n), .w(w), .en(en), .rdy(rdy),
    .y(y), .v(v), .drop(drop), .busy(busy)
  );

  encoder_4x2_queued #(.EDGE(1)) u_edg (
    .clk(clk), .rst_n(rst_n), .w(w_e), .en(en_e), .rdy(1'b1),
    .y(y_e), .v(v_e), .drop(drop_e), .busy(busy_e)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input int got, input int want);
    n_chk++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d want %0d at %0t", tag, got, want, $time);
  endtask

  // Reference model of the level-capture instance; grants go to the scoreboard.
  logic [3:0] m_p    = 4'b0000;
  logic       m_v    = 1'b0;
  logic [1:0] m_y    = 2'b00;
  logic       m_drop = 1'b0;
  int         exp_q[$];

  always @(posedge clk or negedge rst_n) begin : mdl
    logic [3:0] s, c;
    int g;
    if (!rst_n) begin
      m_p = 4'b0000; m_v = 1'b0; m_y = 2'b00; m_drop = 1'b0;
      exp_q.delete();
    end else begin
      s = en ? mask : 4'b0000;
      m_drop = |(s & m_p);
      c = m_p | s;
      if (!m_v || rdy) begin
        g = -1;
        for (int i = 3; i >= 0; i--) if (c[i]) g = i;
        if (g >= 0) begin
          m_y = 2'(g);
          m_v = 1'b1;
          c[g] = 1'b0;
          m_p = c;
          exp_q.push_back(g);
        end else begin
          m_v = 1'b0;
          m_p = 4'b0000;
        end
      end else begin
        m_p = c;
      end
    end
  end

  // take: the last edge could have loaded a new code into y.
  logic       take = 1'b0;
  logic [1:0] last_y = 2'b00;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) take <= 1'b0;
    else        take <= !v || rdy;
  end

  always @(negedge clk) begin
    check("v", v, m_v);
    check("drop", drop, m_drop);
    check("busy", busy, int'(m_v | (m_p != 4'b0000)));
    if (v) begin
      check("y_model", y, m_y);
      if (take) begin
        check("sb_avail", int'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) check("sb_y", y, exp_q.pop_front());
      end else begin
        check("y_hold", y, last_y);
      end
    end
    last_y = y;
  end

  int e_grants = 0;
  always @(negedge clk) begin
    check("e_busy", busy_e, v_e);
    check("e_drop", drop_e, 0);
    if (v_e) begin
      e_grants++;
      check("e_y", y_e, 1);
    end
  end

  task automatic drive(input logic [3:0] m, input logic e, input logic r);
    mask = m; en = e; rdy = r;
    @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_y", y, 0);
    check("rst_v", v, 0);
    check("rst_drop", drop, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    drive(4'b0000, 1'b1, 1'b1);

    // Single request on line 2.
    drive(4'b0100, 1'b1, 1'b1);
    check("single_y", y, 2);
    check("single_v", v, 1);
    drive(4'b0000, 1'b1, 1'b1);
    check("single_v_off", v, 0);
    check("single_busy", busy, 0);

    // All four lines at once drain in priority order.
    drive(4'b1111, 1'b1, 1'b1);
    for (int k = 0; k < 4; k++) begin
      check("drain_y", y, k);
      check("drain_v", v, 1);
      drive(4'b0000, 1'b1, 1'b1);
    end
    check("drain_end_v", v, 0);

    // Back-pressure: lines 0 and 2, consumer stalled for three cycles.
    drive(4'b0101, 1'b1, 1'b0);
    check("bp_y0", y, 0);
    for (int k = 0; k < 2; k++) begin
      drive(4'b0000, 1'b1, 1'b0);
      check("bp_hold_y", y, 0);
      check("bp_hold_v", v, 1);
      check("bp_busy", busy, 1);
    end
    drive(4'b0000, 1'b1, 1'b1);
    check("bp_y2", y, 2);
    drive(4'b0000, 1'b1, 1'b1);
    check("bp_end_v", v, 0);

    // Duplicates while stalled: lines 0 and 3 held three cycles.
    drive(4'b1001, 1'b1, 1'b0);
    check("dup_y", y, 0);
    check("dup_drop0", drop, 0);
    drive(4'b1001, 1'b1, 1'b0);
    check("dup_drop1", drop, 1);
    drive(4'b1001, 1'b1, 1'b0);
    check("dup_drop2", drop, 1);
    drive(4'b0000, 1'b1, 1'b0);
    check("dup_drop3", drop, 0);
    drive(4'b0000, 1'b1, 1'b1);
    check("dup_repend_y", y, 0);
    drive(4'b0000, 1'b1, 1'b1);
    check("dup_y3", y, 3);
    drive(4'b0000, 1'b1, 1'b1);
    check("dup_end_v", v, 0);

    // Same line requested on consecutive free cycles: regranted, no drop.
    drive(4'b0010, 1'b1, 1'b1);
    drive(4'b0010, 1'b1, 1'b1);
    check("regrant_y", y, 1);
    check("regrant_drop", drop, 0);
    drive(4'b0000, 1'b1, 1'b1);

    // Random traffic against the model and scoreboard.
    for (int k = 0; k < 300; k++) begin
      drive(4'($urandom_range(0, 15)), $urandom_range(0, 3) != 0,
            $urandom_range(0, 2) != 0);
    end
    repeat (6) drive(4'b0000, 1'b1, 1'b1);
    check("rand_idle_v", v, 0);
    check("rand_idle_busy", busy, 0);

    // Reset between edges discards the in-flight code and pending lines.
    drive(4'b1111, 1'b1, 1'b0);
    check("mid_v", v, 1);
    check("mid_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_y", y, 0);
    check("mid_rst_v", v, 0);
    check("mid_rst_drop", drop, 0);
    check("mid_rst_busy", busy, 0);
    @(negedge clk);
    mask = 4'b0000; rdy = 1'b1;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drive(4'b0000, 1'b1, 1'b1);
      check("post_rst_v", v, 0);
    end

    // Edge-capture instance.
    check("e_start", e_grants, 0);
    en_e = 1'b1; mask_e = 4'b0000;
    repeat (2) @(negedge clk);
    mask_e = 4'b0010;
    repeat (5) @(negedge clk);
    mask_e = 4'b0000;
    repeat (3) @(negedge clk);
    check("e_one_grant", e_grants, 1);

    en_e = 1'b0; mask_e = 4'b0010;
    repeat (2) @(negedge clk);
    en_e = 1'b1;
    repeat (3) @(negedge clk);
    mask_e = 4'b0000;
    repeat (2) @(negedge clk);
    check("e_masked_edge", e_grants, 1);

    // Line already high at reset release counts as a rising edge.
    mask_e = 4'b0010; en_e = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("e_release_edge", e_grants, 2);
    mask_e = 4'b0000;
    @(negedge clk);

    check("sb_drain", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
